// File: rtl/user_obi_burst_streamer.sv
// OBI burst streamer: moves len 32-bit words between a user stream and SRAM
// over one OBI manager port, keeping up to MaxOutstanding transactions in
// flight. Read data lands in a credit-protected FIFO with a valid/ready output.

package user_obi_burst_pkg;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned IdWidth   = 1;

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic [IdWidth-1:0]     aid;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } obi_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module user_obi_burst_streamer #(
    parameter type         obi_req_t      = user_obi_burst_pkg::obi_req_t,
    parameter type         obi_rsp_t      = user_obi_burst_pkg::obi_rsp_t,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned FifoDepth      = 4,
    parameter int unsigned LenWidth       = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic                                   write_i,
    input  logic [user_obi_burst_pkg::AddrWidth-1:0] base_addr_i,
    input  logic [LenWidth-1:0]                    len_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   err_o,
    input  logic [user_obi_burst_pkg::DataWidth-1:0] wdata_i,
    input  logic                                   wvalid_i,
    output logic                                   wready_o,
    output logic [user_obi_burst_pkg::DataWidth-1:0] rdata_o,
    output logic                                   rvalid_o,
    input  logic                                   rready_i,
    output obi_req_t                               obi_req_o,
    input  obi_rsp_t                               obi_rsp_i
);
    localparam int unsigned AW = user_obi_burst_pkg::AddrWidth;
    localparam int unsigned DW = user_obi_burst_pkg::DataWidth;
    localparam int unsigned OW = $clog2(MaxOutstanding + 1);
    localparam int unsigned CW = $clog2(FifoDepth + 1);
    localparam int unsigned PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_write;
    logic [AW-1:0]         r_base;
    logic [LenWidth-1:0]   r_len, r_issued, r_rsp_cnt;
    logic [OW-1:0]         r_outstanding;
    logic                  r_err, r_done;
    logic [DW-1:0]         r_fifo_mem [FifoDepth];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;

    logic                  w_start_acc, w_rsp, w_push, w_pop, w_credit;
    logic                  w_req, w_gnt_acc, w_last_grant, w_done_set;
    logic [AW-1:0]         w_addr;
    logic                  w_unused;

    assign w_start_acc  = (r_state == S_IDLE) && start_i;
    // Responses are only meaningful inside a burst; late ones after a reset are dropped.
    assign w_rsp        = obi_rsp_i.rvalid && (r_state != S_IDLE);
    assign w_push       = w_rsp && !r_write;
    assign w_pop        = rvalid_o && rready_i;
    // Every in-flight read owns a FIFO slot, so the FIFO can never overflow.
    assign w_credit     = (int'(r_count) + int'(r_outstanding)) < int'(FifoDepth);
    assign w_addr       = r_base + (AW'(r_issued) << 2);
    assign w_last_grant = w_gnt_acc && (r_issued == r_len - LenWidth'(1));
    assign w_unused     = ^obi_rsp_i.r.rid;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic and end-of-burst detection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i && (len_i != '0)) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_last_grant) w_state_nxt = S_WAIT;
            S_WAIT:  if (r_rsp_cnt == r_len) w_state_nxt = r_write ? S_IDLE : S_DRAIN;
            S_DRAIN: if (r_count == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_done_set = (w_start_acc && (len_i == '0)) ||
                     ((r_state != S_IDLE) && (w_state_nxt == S_IDLE));
    end

    // OBI request and write-stream handshake outputs
    always_comb begin
        w_req = (r_state == S_ISSUE) && (r_issued < r_len) &&
                (int'(r_outstanding) < int'(MaxOutstanding)) &&
                (r_write ? wvalid_i : w_credit);
        w_gnt_acc          = w_req && obi_rsp_i.gnt;
        obi_req_o          = '0;
        obi_req_o.req      = w_req;
        obi_req_o.a.addr   = w_addr;
        obi_req_o.a.we     = r_write;
        obi_req_o.a.be     = '1;
        obi_req_o.a.wdata  = ((r_state == S_ISSUE) && r_write) ? wdata_i : '0;
        obi_req_o.a.aid    = '0;
        wready_o           = r_write && w_gnt_acc;
    end

    // Burst bookkeeping: latched command, issue/response counters, sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_write       <= 1'b0;
            r_base        <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_rsp_cnt     <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else if (w_start_acc) begin
            r_write       <= write_i;
            r_base        <= base_addr_i;
            r_len         <= len_i;
            r_issued      <= '0;
            r_rsp_cnt     <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_gnt_acc) r_issued <= r_issued + LenWidth'(1);
            if (w_rsp) begin
                r_rsp_cnt <= r_rsp_cnt + LenWidth'(1);
                if (obi_rsp_i.r.err) r_err <= 1'b1;
            end
            case ({w_gnt_acc, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // One-cycle completion pulse, aligned with busy_o falling
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_done <= 1'b0;
        else         r_done <= w_done_set;
    end

    // Read-data FIFO; storage is cleared on reset so rdata_o starts at zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FifoDepth); i++) r_fifo_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wptr] <= obi_rsp_i.r.rdata;
                r_wptr <= (r_wptr == PW'(FifoDepth - 1)) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= (r_rptr == PW'(FifoDepth - 1)) ? '0 : r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy_o   = (r_state != S_IDLE);
    assign done_o   = r_done;
    assign err_o    = r_err;
    assign rvalid_o = (r_count != '0);
    assign rdata_o  = r_fifo_mem[r_rptr];

endmodule

// File: tb/tb_user_obi_burst_streamer.sv
// Bench for user_obi_burst_streamer: an OBI memory model with configurable
// grant/latency/error behaviour, write/read stream agents, and a burst-level
// reference model (address sequence, data order, completion, error flag).
module tb_user_obi_burst_streamer;
    import user_obi_burst_pkg::*;

    localparam int MO = 2;
    localparam int FD = 4;
    localparam int LW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0, write_i = 1'b0;
    logic [31:0]   base_addr_i = '0;
    logic [LW-1:0] len_i = '0;
    logic          busy_o, done_o, err_o;
    logic [31:0]   wdata_i = '0;
    logic          wvalid_i = 1'b0, wready_o;
    logic [31:0]   rdata_o;
    logic          rvalid_o, rready_i = 1'b0;
    obi_req_t      obi_req_o;
    obi_rsp_t      obi_rsp_i = '0;

    always #5 clk_i = ~clk_i;

    user_obi_burst_streamer #(
        .obi_req_t(obi_req_t), .obi_rsp_t(obi_rsp_t),
        .MaxOutstanding(MO), .FifoDepth(FD), .LenWidth(LW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .write_i(write_i),
        .base_addr_i(base_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .obi_req_o(obi_req_o), .obi_rsp_i(obi_rsp_i)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // ---------------- memory model and agents ----------------
    typedef struct { int due; logic [31:0] data; logic err; } pend_t;
    pend_t       rq[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_q[$];
    int cyc = 0;
    int gnt_mode = 0, lat = 1, err_pct = 0, err_at = -1, rr_mode = 0, rr_release = 0;
    bit wv_toggle = 0, wv_rand = 0, force_err = 0;
    int wait_cnt = 0;
    bit w_taken = 0, w_gap = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ((a * 32'h9E37_79B9) ^ 32'h5A5A_1234);
    endfunction

    // Drive memory response channel and both streams just after each edge
    always @(posedge clk_i) begin
        cyc++;
        #1;
        case (gnt_mode)
            0:       obi_rsp_i.gnt = 1'b1;
            1:       obi_rsp_i.gnt = 1'($urandom_range(1));
            default: obi_rsp_i.gnt = (wait_cnt >= 2);
        endcase
        obi_rsp_i.rvalid  = (rq.size() > 0) && (rq[0].due <= cyc);
        obi_rsp_i.r.rdata = obi_rsp_i.rvalid ? rq[0].data : $urandom;
        obi_rsp_i.r.err   = obi_rsp_i.rvalid && (rq[0].err || force_err);
        obi_rsp_i.r.rid   = '0;
        if (w_taken) begin
            void'(wr_q.pop_front());
            wvalid_i = 1'b0; w_gap = wv_toggle; w_taken = 0;
        end
        if (!wvalid_i) begin
            if (w_gap) w_gap = 0;
            else if (wr_q.size() > 0 && (!wv_rand || $urandom_range(1) == 1)) wvalid_i = 1'b1;
        end
        wdata_i = wvalid_i ? wr_q[0] : $urandom;
        case (rr_mode)
            0:       rready_i = 1'b1;
            1:       rready_i = 1'($urandom_range(1));
            default: rready_i = (cyc >= rr_release);
        endcase
    end

    // ---------------- monitor ----------------
    int n_gnt, n_rsp, n_pop, n_wready, n_done, n_reqcyc, n_busy, first_req_cyc, first_rv_cyc;
    int viol_stab, viol_credit, viol_wv, viol_out, viol_done, max_buf;
    logic [31:0] iss_addr[$], iss_wdata[$], out_q[$];
    logic        iss_we[$];
    int          gnt_cyc[$];
    logic        err_exp, pend, prev_done;
    logic [31:0] pend_addr;

    task automatic clear_mon();
        n_gnt = 0; n_rsp = 0; n_pop = 0; n_wready = 0; n_done = 0; n_reqcyc = 0; n_busy = 0;
        first_req_cyc = -1; first_rv_cyc = -1;
        viol_stab = 0; viol_credit = 0; viol_wv = 0; viol_out = 0; viol_done = 0; max_buf = 0;
        iss_addr.delete(); iss_wdata.delete(); out_q.delete(); iss_we.delete(); gnt_cyc.delete();
        err_exp = 0; pend = 0; prev_done = 0; pend_addr = '0;
    endtask

    always @(negedge clk_i) begin
        logic [31:0] a;
        logic        e;
        if (obi_rsp_i.rvalid) begin void'(rq.pop_front()); n_rsp++; end
        if (obi_req_o.req && !obi_rsp_i.gnt) wait_cnt++; else wait_cnt = 0;
        if (wvalid_i && wready_o) w_taken = 1;
        if (rst_ni) begin
            a = obi_req_o.a.addr;
            if (obi_req_o.req) begin
                n_reqcyc++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (pend && a !== pend_addr) viol_stab++;
                if (!obi_req_o.a.we && (n_gnt - n_pop) >= FD) viol_credit++;
                if ((n_gnt - n_rsp) >= MO) viol_out++;
                if (obi_req_o.a.we && !wvalid_i) viol_wv++;
            end
            pend = obi_req_o.req && !obi_rsp_i.gnt;
            pend_addr = a;
            if (obi_req_o.req && obi_rsp_i.gnt) begin
                iss_addr.push_back(a); iss_we.push_back(obi_req_o.a.we);
                iss_wdata.push_back(obi_req_o.a.wdata); gnt_cyc.push_back(cyc);
                if (obi_req_o.a.we) mem[a] = obi_req_o.a.wdata;
                e = (n_gnt == err_at) || ($urandom_range(99) < err_pct);
                err_exp |= e;
                rq.push_back('{due: cyc + lat, data: obi_req_o.a.we ? 32'h0 : mem_rd(a), err: e});
                n_gnt++;
            end
            if (wready_o) n_wready++;
            if (rvalid_o && first_rv_cyc < 0) first_rv_cyc = cyc;
            if (rvalid_o && rready_i) begin out_q.push_back(rdata_o); n_pop++; end
            if ((n_gnt - n_pop) > max_buf) max_buf = n_gnt - n_pop;
            if (done_o && (busy_o || prev_done)) viol_done++;
            if (done_o) n_done++;
            if (busy_o) n_busy++;
            prev_done = done_o;
        end
    end

    // ---------------- directed-step helpers ----------------
    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic start_burst(input logic w, input logic [31:0] b, input int n, output int s);
        start_i = 1'b1; write_i = w; base_addr_i = b; len_i = LW'(n); s = cyc;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int d);
        d = -1;
        for (int i = 0; i < budget && d < 0; i++) begin
            @(negedge clk_i);
            if (done_o) d = cyc;
        end
        chk({tag, "_done_seen"}, (d >= 0), 1);
        tick();
    endtask

    task automatic mk_exp(input logic [31:0] b, input int n, output logic [31:0] q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(mem_rd(b + 32'(4 * i)));
    endtask

    task automatic mk_wr(input int n, output logic [31:0] q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back($urandom);
        wr_q = q;
    endtask

    task automatic check_burst(input string tag, input logic w, input logic [31:0] b,
                               input int n, input logic [31:0] ev[$]);
        int bad_a = 0, bad_d = 0;
        chk({tag, "_ngrant"}, n_gnt, n);
        for (int i = 0; i < iss_addr.size(); i++)
            if (iss_addr[i] !== b + 32'(4 * i) || iss_we[i] !== w) bad_a++;
        chk({tag, "_addr_seq"}, bad_a, 0);
        if (w) begin
            for (int i = 0; i < n; i++)
                if (i >= iss_wdata.size() || iss_wdata[i] !== ev[i]) bad_d++;
            chk({tag, "_wready_cnt"}, n_wready, n);
        end else begin
            chk({tag, "_nread"}, out_q.size(), n);
            for (int i = 0; i < n; i++)
                if (i >= out_q.size() || out_q[i] !== ev[i]) bad_d++;
        end
        chk({tag, "_data"}, bad_d, 0);
        chk({tag, "_ndone"}, n_done, 1);
        chk({tag, "_done_shape"}, viol_done, 0);
        chk({tag, "_max_out"}, viol_out, 0);
        chk({tag, "_addr_stable"}, viol_stab, 0);
        chk({tag, "_credit"}, viol_credit, 0);
        chk({tag, "_err"}, err_o, err_exp);
    endtask

    task automatic check_reset(input string t);
        chk({t, "_req"}, obi_req_o.req, 0);
        chk({t, "_addr"}, obi_req_o.a.addr, 0);
        chk({t, "_we"}, obi_req_o.a.we, 0);
        chk({t, "_be"}, obi_req_o.a.be, 4'hF);
        chk({t, "_wdata"}, obi_req_o.a.wdata, 0);
        chk({t, "_aid"}, obi_req_o.a.aid, 0);
        chk({t, "_busy"}, busy_o, 0);
        chk({t, "_done"}, done_o, 0);
        chk({t, "_err"}, err_o, 0);
        chk({t, "_wready"}, wready_o, 0);
        chk({t, "_rvalid"}, rvalid_o, 0);
        chk({t, "_rdata"}, rdata_o, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s, d, k, n;
        logic        w;
        logic [31:0] b;
        logic [31:0] ev[$];
        clear_mon();
        repeat (2) @(posedge clk_i);
        #1;
        check_reset("reset");
        rst_ni = 1'b1;
        tick();

        // Read burst, full-speed memory
        clear_mon(); gnt_mode = 0; lat = 1; rr_mode = 0;
        mk_exp(32'h1000_0000, 4, ev);
        start_burst(1'b0, 32'h1000_0000, 4, s);
        chk("t1_busy_c1", busy_o, 1);
        wait_done("t1", 60, d);
        check_burst("t1", 1'b0, 32'h1000_0000, 4, ev);
        chk("t1_first_req", first_req_cyc, s + 1);
        chk("t1_first_rvalid", first_rv_cyc, s + 3);
        chk("t1_b2b_grants", (gnt_cyc.size() == 4) ? gnt_cyc[3] - gnt_cyc[0] : -1, 3);

        // Read backpressure: output stalled for 20 cycles
        clear_mon(); rr_mode = 2; rr_release = cyc + 21;
        mk_exp(32'h2000_0040, 8, ev);
        start_burst(1'b0, 32'h2000_0040, 8, s);
        wait_done("t2", 200, d);
        check_burst("t2", 1'b0, 32'h2000_0040, 8, ev);
        chk("t2_max_buffered", max_buf, FD);
        rr_mode = 0;

        // Write burst, toggling wvalid, grant delayed 2 cycles
        clear_mon(); gnt_mode = 2; wv_toggle = 1;
        mk_wr(3, ev);
        start_burst(1'b1, 32'h3000_0100, 3, s);
        wait_done("t3", 100, d);
        check_burst("t3", 1'b1, 32'h3000_0100, 3, ev);
        chk("t3_req_needs_wvalid", viol_wv, 0);
        chk("t3_waited", (n_reqcyc > 3), 1);
        chk("t3_mem1", mem_rd(32'h3000_0104), ev[1]);
        gnt_mode = 0; wv_toggle = 0;

        // Error on second read response
        clear_mon(); err_at = 1;
        mk_exp(32'h1000_0000, 2, ev);
        start_burst(1'b0, 32'h1000_0000, 2, s);
        wait_done("t4", 60, d);
        check_burst("t4", 1'b0, 32'h1000_0000, 2, ev);
        chk("t4_err_sticky", err_o, 1);
        err_at = -1;

        // Zero-length burst clears the error and completes without traffic
        clear_mon();
        start_burst(1'b0, 32'h5000_0000, 0, s);
        chk("t5_err_cleared", err_o, 0);
        wait_done("t5", 10, d);
        chk("t5_done_cycle", d, s + 1);
        chk("t5_no_req", n_reqcyc, 0);
        chk("t5_never_busy", n_busy, 0);

        // Address wrap at top of the address space
        clear_mon(); gnt_mode = 1; lat = 2;
        mk_exp(32'hFFFF_FFF8, 3, ev);
        start_burst(1'b0, 32'hFFFF_FFF8, 3, s);
        wait_done("t6", 100, d);
        check_burst("t6", 1'b0, 32'hFFFF_FFF8, 3, ev);
        chk("t6_wrap_addr", (iss_addr.size() == 3) ? iss_addr[2] : 32'hDEAD_DEAD, 32'h0);

        // Reset with two reads in flight; late (erroneous) responses must be ignored
        clear_mon(); gnt_mode = 0; lat = 4;
        start_burst(1'b0, 32'h4000_0000, 8, s);
        k = 0;
        while ((n_gnt - n_rsp) < 2 && k < 20) begin tick(); k++; end
        chk("t7_two_outstanding", n_gnt - n_rsp, 2);
        force_err = 1;
        rst_ni = 1'b0;
        #1;
        check_reset("t7_mid");
        tick();
        rst_ni = 1'b1;
        k = 0;
        while (rq.size() > 0 && k < 20) begin tick(); k++; end
        tick();
        chk("t7_late_drained", rq.size(), 0);
        chk("t7_rvalid_after", rvalid_o, 0);
        chk("t7_err_after", err_o, 0);
        chk("t7_busy_after", busy_o, 0);
        force_err = 0; lat = 1;
        clear_mon();
        mk_exp(32'h4000_0100, 4, ev);
        start_burst(1'b0, 32'h4000_0100, 4, s);
        wait_done("t7b", 60, d);
        check_burst("t7b", 1'b0, 32'h4000_0100, 4, ev);

        // Randomized bursts against the burst-level model
        for (int r = 0; r < 6; r++) begin
            clear_mon();
            w = 1'($urandom_range(1)); n = $urandom_range(1, 10);
            b = $urandom & 32'hFFFF_FFFC;
            gnt_mode = 1; lat = $urandom_range(1, 3); rr_mode = 1; wv_rand = 1; err_pct = 20;
            if (w) mk_wr(n, ev); else mk_exp(b, n, ev);
            start_burst(w, b, n, s);
            wait_done($sformatf("rnd%0d", r), 500, d);
            check_burst($sformatf("rnd%0d", r), w, b, n, ev);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
